data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Byte-addressed data memory that sits directly downstream of the 64-bit ALU in the single-cycle CPU.
- The ALU result (`out`) drives `addr`; register-file operand B drives `wdata`.
- Loads are combinational so the result is usable in the same cycle. Stores commit on the rising clock edge.
- Supports byte, half, word and doubleword accesses with sign/zero extension, alignment and range checking, a sticky fault record, and a committed-store counter.

Parameters:
- DEPTH, 64, number of 64-bit doubleword entries (power of two, ≥2).
- AW, $clog2(DEPTH), entry index width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  64  byte address (ALU out)
- wdata  in  64  store data; low bytes used for narrow sizes
- mem_read  in  1  load enable
- mem_write  in  1  store enable
- size  in  2  00 byte, 01 half, 10 word, 11 double
- sign_ext  in  1  1 = sign-extend narrow loads, 0 = zero-extend
- fault_clr  in  1  clears sticky fault
- rdata  out  64  load result
- misalign  out  1  combinational alignment error for current access
- oob  out  1  combinational out-of-range error for current access
- fault  out  1  sticky fault flag
- fault_addr  out  64  address of first faulting access
- store_count  out  32  number of committed stores

Behaviour:
- **Reset:** one clock; reset is asynchronous and active-low (`clk`, `rst_n`). On `rst_n` low, all DEPTH entries clear to 0, `fault`=0, `fault_addr`=0, `store_count`=0. `rdata` then reads 0 for any access.
- **Memory layout:**
  - Little-endian.
  - Entry index = `addr[AW+2:3]`; byte offset = `addr[2:0]`.
- **Error conditions:**
  - `oob` = (`mem_read` | `mem_write`) & (`addr` ≥ DEPTH*8). Compute the comparison on the full 64 bits.
  - `misalign` = (`mem_read` | `mem_write`) & !`oob` & alignment violated:
    - half: `addr[0]` ≠ 0
    - word: `addr[1:0]` ≠ 0
    - double: `addr[2:0]` ≠ 0
    - byte: never misaligned
  - `err` = `oob` | `misalign`.
- **Load (combinational, zero latency):**
  - If `mem_read` & !`err`: select the bytes at the offset, then sign- or zero-extend from bit 7/15/31 per `size`. Double ignores `sign_ext`.
  - Otherwise `rdata`=0.
- **Store (commits at posedge):**
  - If `mem_write` & !`err` & `rst_n`: write only the bytes selected by `size`/offset. Other bytes of the entry are unchanged.
  - On a faulting store, memory is untouched.
- **Read and write in the same cycle:** the store commits, and `rdata` shows the pre-write contents during that cycle.
- **store_count:** increments by 1 on each committed store and wraps from 0xFFFF_FFFF to 0. Faulting stores do not count.
- **Sticky fault register (posedge):**
  - If `err`: when `fault`=0 or `fault_clr`=1, set `fault`=1 and capture `fault_addr`=`addr`. Otherwise hold; the first fault wins.
  - Else if `fault_clr`: `fault`=0. `fault_addr` holds its last value.
  - `fault_clr` together with a new error: the new error wins (set, capture the new address).
- **Reset mid-operation:** asynchronous clear overrides any same-cycle store. The first edge after `rst_n` rises behaves normally.
- An idle cycle (`mem_read`=`mem_write`=0) produces no error, no state change, and `rdata`=0.

Decomposition:
- **Shared package (`cpu_pkg`):**
  - `mem_size_t` enum: SZ_B, SZ_H, SZ_W, SZ_D.
  - `DMEM_DEPTH` default.
  - A function returning the byte-lane mask (8 bits) for a given size and offset.
- **Sub-module `load_align`** (purely combinational): takes the entry, offset, `size` and `sign_ext`; produces the extended `rdata`. It is natural to split out and unit-test separately.
- The array, store, fault and counter logic stay in `data_mem`.

Test Plan:
1. Reset, then double store `addr`=0x10, `wdata`=0x8877665544332211, then double load at 0x10 → `rdata`=0x8877665544332211; `store_count`=1.
2. Byte load at 0x17 with `sign_ext`=1 → 0xFFFFFFFFFFFFFF88; with `sign_ext`=0 → 0x88. Half load at 0x16 signed → 0xFFFFFFFFFFFF8877.
3. Word store 0xDEADBEEF at 0x14 → a double read of 0x10 gives 0xDEADBEEF44332211 (lower word preserved); `store_count`=2.
4. Word store at 0x12 → `misalign`=1, memory unchanged, `store_count` unchanged, `fault`=1, `fault_addr`=0x12. A later load at `addr`=0x200 (DEPTH=64) gives `oob`=1 and `rdata`=0, while `fault_addr` stays 0x12.
5. `fault_clr` pulsed together with a misaligned half read at 0x21 → `fault`=1, `fault_addr`=0x21. `fault_clr` alone next cycle → `fault`=0.
6. Read+write of 0x10 in one cycle (old value 0xDEADBEEF44332211, new 0x1) → `rdata`=0xDEADBEEF44332211 that cycle and 0x1 the next. Asserting `rst_n`=0 mid-cycle between edges clears everything immediately, so a read of 0x10 returns 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared access-size type, data-memory depth and byte-lane helper
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_t;

  localparam int DMEM_DEPTH = 64;

  // Lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [7:0] lane_mask(input mem_size_t sz, input logic [2:0] off);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed bytes out of a doubleword and extends them
module load_align
  import cpu_pkg::*;
(
  input  logic [63:0] entry,
  input  logic [2:0]  offset,
  input  mem_size_t   size,
  input  logic        sign_ext,
  output logic [63:0] rdata
);

  logic [63:0] shifted;

  always_comb begin
    shifted = entry >> {offset, 3'b000};
    rdata   = shifted;
    case (size)
      SZ_B:    rdata = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      SZ_H:    rdata = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_W:    rdata = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-addressed data memory: combinational loads, posedge stores,
// alignment/range checks, sticky fault record and committed-store counter
module data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic        fault_clr,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        oob,
  output logic        fault,
  output logic [63:0] fault_addr,
  output logic [31:0] store_count
);

  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];
  logic        fault_q, fault_d;
  logic [63:0] fault_addr_q, fault_addr_d;
  logic [31:0] store_count_q, store_count_d;

  mem_size_t   sz;
  logic        active, misal_raw, err, wr_en;
  logic [AW-1:0] idx;
  logic [2:0]  off;
  logic [7:0]  mask;
  logic [63:0] entry, wshift, merged, la_rdata;

  assign sz     = mem_size_t'(size);
  assign active = mem_read | mem_write;
  assign idx    = addr[AW+2:3];
  assign off    = addr[2:0];
  assign entry  = mem_q[idx];
  assign oob    = active & (addr >= LIMIT);

  always_comb begin
    misal_raw = 1'b0;
    case (sz)
      SZ_B:    misal_raw = 1'b0;
      SZ_H:    misal_raw = addr[0];
      SZ_W:    misal_raw = |addr[1:0];
      default: misal_raw = |addr[2:0];
    endcase
  end

  assign misalign = active & ~oob & misal_raw;
  assign err      = oob | misalign;
  assign wr_en    = mem_write & ~err;

  load_align u_load_align (
    .entry    (entry),
    .offset   (off),
    .size     (sz),
    .sign_ext (sign_ext),
    .rdata    (la_rdata)
  );

  // Reads see the pre-store contents because mem_q only changes at the edge.
  assign rdata = (mem_read & ~err) ? la_rdata : 64'd0;

  assign mask   = lane_mask(sz, off);
  assign wshift = wdata << {off, 3'b000};

  always_comb begin
    for (int b = 0; b < 8; b++) begin
      merged[b*8 +: 8] = mask[b] ? wshift[b*8 +: 8] : entry[b*8 +: 8];
    end
  end

  always_comb begin
    mem_d         = mem_q;
    store_count_d = store_count_q + 32'(wr_en);
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    if (wr_en) begin
      mem_d[idx] = merged;
    end
    // First fault wins unless software clears in the same cycle as a new one.
    if (err) begin
      if (!fault_q || fault_clr) begin
        fault_d      = 1'b1;
        fault_addr_d = addr;
      end
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      store_count_q <= '0;
    end else begin
      mem_q         <= mem_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      store_count_q <= store_count_d;
    end
  end

  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed and randomized bench for data_mem against a byte-array model
module tb_data_mem;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic        fault_clr = 1'b0;
  logic [63:0] rdata;
  logic        misalign;
  logic        oob;
  logic        fault;
  logic [63:0] fault_addr;
  logic [31:0] store_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mm [NBYTES];
  logic        m_fault;
  logic [63:0] m_fault_addr;
  logic [31:0] m_count;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .wdata       (wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .sign_ext    (sign_ext),
    .fault_clr   (fault_clr),
    .rdata       (rdata),
    .misalign    (misalign),
    .oob         (oob),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_oob(input logic [63:0] a, input logic rd, input logic wr);
    return (rd | wr) && (a >= 64'(NBYTES));
  endfunction

  function automatic bit m_mis(input logic [63:0] a, input logic [1:0] sz, input logic rd,
                               input logic wr);
    return (rd | wr) && !m_oob(a, rd, wr) && ((a % (64'd1 << sz)) != 0);
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] sz,
                                         input logic sx);
    int n = 1 << sz;
    int base = int'(a[15:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[base + i];
    if (sz != 2'd3 && sx && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
      m_fault = 1'b0;
      m_fault_addr = '0;
      m_count = '0;
    end else begin
      bit e;
      e = m_oob(addr, mem_read, mem_write) || m_mis(addr, size, mem_read, mem_write);
      if (mem_write && !e) begin
        for (int i = 0; i < (1 << size); i++) mm[int'(addr[15:0]) + i] = wdata[8*i +: 8];
        m_count = m_count + 32'd1;
      end
      if (e) begin
        if (!m_fault || fault_clr) begin
          m_fault = 1'b1;
          m_fault_addr = addr;
        end
      end else if (fault_clr) begin
        m_fault = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit o, m;
      logic [63:0] exp_rd;
      o = m_oob(addr, mem_read, mem_write);
      m = m_mis(addr, size, mem_read, mem_write);
      exp_rd = (mem_read && !o && !m) ? m_load(addr, size, sign_ext) : 64'd0;
      check("cyc_rdata", rdata, exp_rd);
      check("cyc_oob", 64'(oob), 64'(o));
      check("cyc_misalign", 64'(misalign), 64'(m));
      check("cyc_fault", 64'(fault), 64'(m_fault));
      check("cyc_fault_addr", fault_addr, m_fault_addr);
      check("cyc_store_count", 64'(store_count), 64'(m_count));
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic clr, input logic [63:0] a, input logic [63:0] wd);
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    fault_clr = clr; addr = a; wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 2'd0, 0, 0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #7 rst_n = 1'b1;
    chk_en = 1'b1;
    next_cycle();

    #1;
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_fault_addr", fault_addr, 64'd0);
    check("rst_store_count", 64'(store_count), 64'd0);

    drive(0, 1, 2'd3, 0, 0, 64'h10, 64'h8877665544332211);
    next_cycle();
    drive(1, 0, 2'd3, 0, 0, 64'h10, 64'd0);
    #1;
    check("t1_dload", rdata, 64'h8877665544332211);
    check("t1_count", 64'(store_count), 64'd1);

    drive(1, 0, 2'd0, 1, 0, 64'h17, 64'd0); #1;
    check("t2_byte_sx", rdata, 64'hFFFFFFFFFFFFFF88);
    drive(1, 0, 2'd0, 0, 0, 64'h17, 64'd0); #1;
    check("t2_byte_zx", rdata, 64'h88);
    drive(1, 0, 2'd1, 1, 0, 64'h16, 64'd0); #1;
    check("t2_half_sx", rdata, 64'hFFFFFFFFFFFF8877);

    drive(0, 1, 2'd2, 0, 0, 64'h14, 64'hDEADBEEF);
    next_cycle();
    drive(1, 0, 2'd3, 0, 0, 64'h10, 64'd0); #1;
    check("t3_dload", rdata, 64'hDEADBEEF44332211);
    check("t3_count", 64'(store_count), 64'd2);

    drive(0, 1, 2'd2, 0, 0, 64'h12, 64'h12345678); #1;
    check("t4_misalign", 64'(misalign), 64'd1);
    next_cycle();
    drive(1, 0, 2'd3, 0, 0, 64'h10, 64'd0); #1;
    check("t4_fault", 64'(fault), 64'd1);
    check("t4_fault_addr", fault_addr, 64'h12);
    check("t4_count", 64'(store_count), 64'd2);
    check("t4_unchanged", rdata, 64'hDEADBEEF44332211);
    drive(1, 0, 2'd3, 0, 0, 64'h200, 64'd0); #1;
    check("t4_oob", 64'(oob), 64'd1);
    check("t4_oob_rdata", rdata, 64'd0);
    next_cycle();
    check("t4_first_wins", fault_addr, 64'h12);

    drive(1, 0, 2'd1, 1, 1, 64'h21, 64'd0);
    next_cycle();
    check("t5_fault", 64'(fault), 64'd1);
    check("t5_fault_addr", fault_addr, 64'h21);
    drive(0, 0, 2'd0, 0, 1, 64'd0, 64'd0);
    next_cycle();
    check("t5_clr", 64'(fault), 64'd0);
    check("t5_addr_held", fault_addr, 64'h21);

    drive(1, 1, 2'd3, 0, 0, 64'h10, 64'h1); #1;
    check("t6_rw_old", rdata, 64'hDEADBEEF44332211);
    next_cycle();
    drive(1, 0, 2'd3, 0, 0, 64'h10, 64'd0); #1;
    check("t6_rw_new", rdata, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_rdata", rdata, 64'd0);
    check("t6_rst_count", 64'(store_count), 64'd0);
    check("t6_rst_fault_addr", fault_addr, 64'd0);
    #3 rst_n = 1'b1;

    for (int c = 0; c < 2000; c++) begin
      logic [63:0] a;
      logic [1:0] sz;
      int r;
      next_cycle();
      sz = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r <= 4) a = 64'($urandom_range(0, NBYTES - 1));
      else if (r <= 6) a = 64'($urandom_range(NBYTES - 16, NBYTES + 15));
      else if (r == 7) a = {32'($urandom), 32'($urandom)};
      else a = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), a, {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    next_cycle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
